// File: rtl/lif_pkg.sv
// Shared types and helpers for the time-multiplexed LIF neuron array.
package lif_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} lif_state_e;

  // Index width that never collapses to zero bits for a single entry.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned max_val);
    int unsigned s;
    s = a + b;
    return (s > max_val) ? max_val : s;
  endfunction

endpackage

// File: rtl/lif_core.sv
// Combinational single-channel update: leak, integrate with saturation, fire, refractory.
module lif_core
  import lif_pkg::*;
#(
  parameter int W          = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRAC     = 2,
  parameter int RESET_MODE = 0,
  localparam int RW        = clog2_min1(REFRAC + 1)
) (
  input  logic [W-1:0]  i_v,
  input  logic [W-1:0]  i_cur,
  input  logic [W-1:0]  i_thresh,
  input  logic [RW-1:0] i_ref,
  output logic [W-1:0]  o_v_next,
  output logic [RW-1:0] o_ref_next,
  output logic          o_spike
);

  localparam int unsigned VMAX = (2 ** W) - 1;

  logic [W-1:0] w_leaked;
  logic [W-1:0] w_sum;

  assign w_leaked = i_v - (i_v >> LEAK_SHIFT);
  assign w_sum    = W'(sat_add(32'(w_leaked), 32'(i_cur), VMAX));

  // NOTE: every output gets a default first so no path through the if-chain can infer a latch.
  always_comb begin
    o_v_next   = w_sum;
    o_ref_next = '0;
    o_spike    = 1'b0;
    if (REFRAC > 0 && i_ref != '0) begin
      o_v_next   = '0;
      o_ref_next = i_ref - RW'(1);
    end else if (w_sum >= i_thresh) begin
      o_spike    = 1'b1;
      o_ref_next = RW'(REFRAC);
      o_v_next   = (RESET_MODE != 0) ? (w_sum - i_thresh) : '0;
    end
  end

endmodule

// File: rtl/lif_array.sv
// N_CH leaky integrate-and-fire neurons sharing one lif_core, one channel per clock.
module lif_array
  import lif_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int W          = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRAC     = 2,
  parameter int RESET_MODE = 0,
  localparam int SEL_W     = clog2_min1(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic [N_CH*W-1:0] current,
  input  logic [W-1:0]      thresh,
  input  logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              done,
  output logic [N_CH-1:0]   spike,
  output logic [W-1:0]      state
);

  localparam int IDX_W = clog2_min1(N_CH);
  localparam int RW    = clog2_min1(REFRAC + 1);

  lif_state_e        r_state;
  logic [IDX_W-1:0]  r_ch_idx;
  logic [N_CH*W-1:0] r_cur;
  logic [W-1:0]      r_thresh;
  logic [W-1:0]      r_v   [N_CH];
  logic [RW-1:0]     r_ref [N_CH];
  logic [N_CH-1:0]   r_spk_acc;
  logic [N_CH-1:0]   r_spike;
  logic              r_busy;
  logic              r_done;

  logic [W-1:0]      w_v_cur;
  logic [W-1:0]      w_i_cur;
  logic [RW-1:0]     w_ref_cur;
  logic [W-1:0]      w_v_next;
  logic [RW-1:0]     w_ref_next;
  logic              w_spk;
  logic [N_CH-1:0]   w_spk_vec;
  logic              w_last;

  // Route the active channel's state and snapshotted current into the shared core.
  always_comb begin
    w_v_cur   = '0;
    w_i_cur   = '0;
    w_ref_cur = '0;
    w_spk_vec = r_spk_acc;
    for (int c = 0; c < N_CH; c++) begin
      if (r_ch_idx == IDX_W'(c)) begin
        w_v_cur      = r_v[c];
        w_i_cur      = r_cur[c*W +: W];
        w_ref_cur    = r_ref[c];
        w_spk_vec[c] = w_spk;
      end
    end
  end

  assign w_last = (r_ch_idx == IDX_W'(N_CH - 1));

  lif_core #(
    .W          (W),
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRAC     (REFRAC),
    .RESET_MODE (RESET_MODE)
  ) u_core (
    .i_v        (w_v_cur),
    .i_cur      (w_i_cur),
    .i_thresh   (r_thresh),
    .i_ref      (w_ref_cur),
    .o_v_next   (w_v_next),
    .o_ref_next (w_ref_next),
    .o_spike    (w_spk)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ch_idx  <= '0;
      r_cur     <= '0;
      r_thresh  <= '0;
      r_spk_acc <= '0;
      r_spike   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      // NOTE: the membrane and refractory arrays are real state visible on the readout, so they are reset too.
      for (int c = 0; c < N_CH; c++) begin
        r_v[c]   <= '0;
        r_ref[c] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          r_state <= IDLE;
          if (step) begin
            r_cur    <= current;
            r_thresh <= thresh;
            r_ch_idx <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          for (int c = 0; c < N_CH; c++) begin
            if (r_ch_idx == IDX_W'(c)) begin
              r_v[c]   <= w_v_next;
              r_ref[c] <= w_ref_next;
            end
          end
          r_spk_acc <= w_spk_vec;
          if (w_last) begin
            r_spike <= w_spk_vec;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_ch_idx <= r_ch_idx + IDX_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Out-of-range selects read as zero.
  always_comb begin
    state = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (sel == SEL_W'(c)) state = r_v[c];
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign spike = r_spike;

endmodule

// File: tb/tb_lif_array.sv
// Directed bench for lif_array: reset-to-zero instance plus a subtract-threshold instance.
module tb_lif_array;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step = 1'b0;
  logic [31:0] current = '0;
  logic [7:0]  thresh = '0;
  logic [1:0]  sel = '0;

  logic        busy_0, done_0, busy_1, done_1;
  logic [3:0]  spike_0, spike_1;
  logic [7:0]  state_0, state_1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lif_array #(.N_CH(4), .W(8), .LEAK_SHIFT(1), .REFRAC(2), .RESET_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .step(step), .current(current), .thresh(thresh), .sel(sel),
    .busy(busy_0), .done(done_0), .spike(spike_0), .state(state_0)
  );

  lif_array #(.N_CH(4), .W(8), .LEAK_SHIFT(1), .REFRAC(2), .RESET_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .step(step), .current(current), .thresh(thresh), .sel(sel),
    .busy(busy_1), .done(done_1), .spike(spike_1), .state(state_1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    step = 1'b0;
    rst  = 1'b1;
    tick();
    tick();
    rst  = 1'b0;
  endtask

  task automatic read_state(input int ch, output logic [7:0] v0, output logic [7:0] v1);
    sel = 2'(ch);
    #1;
    v0 = state_0;
    v1 = state_1;
  endtask

  // One timestep on dut0, checking latency and busy framing, ending back in IDLE.
  task automatic do_step(input logic [31:0] cur, input logic [7:0] thr);
    int lat;
    bit busy_ok;
    current = cur;
    thresh  = thr;
    step    = 1'b1;
    tick();
    step    = 1'b0;
    lat     = 1;
    busy_ok = 1'b1;
    while (done_0 !== 1'b1 && lat < 20) begin
      if (busy_0 !== 1'b1) busy_ok = 1'b0;
      tick();
      lat++;
    end
    checks++;
    if (lat !== 5) begin
      failures++;
      $display("FAIL step_latency got=%0d exp=5", lat);
    end
    checks++;
    if (busy_0 !== 1'b0 || !busy_ok) begin
      failures++;
      $display("FAIL busy_frame busy_at_done=%b busy_high_during_run=%b exp 0/1", busy_0, busy_ok);
    end
    tick();
  endtask

  task automatic test_reset();
    logic [7:0] v0, v1;
    apply_reset();
    checks++;
    if ({busy_0, done_0, spike_0} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b done=%b spike=%b exp all 0", busy_0, done_0, spike_0);
    end
    do_step(32'h0, 8'd150);
    checks++;
    if (spike_0 !== 4'b0000) begin
      failures++;
      $display("FAIL zero_input_spike got=%b exp=0000", spike_0);
    end
    for (int c = 0; c < 4; c++) begin
      read_state(c, v0, v1);
      checks++;
      if (v0 !== 8'd0) begin
        failures++;
        $display("FAIL zero_input_state ch%0d got=%0d exp=0", c, v0);
      end
    end
  endtask

  task automatic test_integrate_refrac();
    logic [7:0] ev [5] = '{8'd100, 8'd0, 8'd0, 8'd0, 8'd100};
    logic [3:0] es [5] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    logic [7:0] v0, v1;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      do_step(32'd100, 8'd150);
      read_state(0, v0, v1);
      checks++;
      if (v0 !== ev[k] || spike_0 !== es[k]) begin
        failures++;
        $display("FAIL integrate_refrac step%0d V0=%0d spike=%b exp V0=%0d spike=%b",
                 k + 1, v0, spike_0, ev[k], es[k]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] v0, v1;
    apply_reset();
    do_step(32'd200 << 8, 8'd255);
    read_state(1, v0, v1);
    checks++;
    if (v0 !== 8'd200 || spike_0 !== 4'b0000) begin
      failures++;
      $display("FAIL sat_step1 V1=%0d spike=%b exp V1=200 spike=0000", v0, spike_0);
    end
    do_step(32'd200 << 8, 8'd255);
    read_state(1, v0, v1);
    checks++;
    if (v0 !== 8'd0 || spike_0 !== 4'b0010) begin
      failures++;
      $display("FAIL sat_step2 V1=%0d spike=%b exp V1=0 spike=0010", v0, spike_0);
    end
  endtask

  task automatic test_thresh_zero();
    logic [3:0] es [4] = '{4'b1111, 4'b0000, 4'b0000, 4'b1111};
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      do_step(32'h0, 8'd0);
      checks++;
      if (spike_0 !== es[k]) begin
        failures++;
        $display("FAIL thresh_zero step%0d spike=%b exp=%b", k + 1, spike_0, es[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_done;
    int first_at;
    logic [7:0] v0, v1;
    apply_reset();
    current = 32'd10;
    thresh  = 8'd150;
    step    = 1'b1;
    tick();
    step    = 1'b0;
    current = 32'd99;
    tick();
    step    = 1'b1;
    tick();
    step    = 1'b0;
    n_done   = 0;
    first_at = -1;
    for (int cyc = 3; cyc < 13; cyc++) begin
      if (done_0 === 1'b1) begin
        n_done++;
        if (first_at < 0) first_at = cyc;
      end
      tick();
    end
    checks++;
    if (n_done !== 1 || first_at !== 5) begin
      failures++;
      $display("FAIL ignored_step dones=%0d first_at=t+%0d exp 1 at t+5", n_done, first_at);
    end
    read_state(0, v0, v1);
    checks++;
    if (v0 !== 8'd10) begin
      failures++;
      $display("FAIL snapshot V0=%0d exp=10", v0);
    end
  endtask

  task automatic test_abort();
    logic [7:0] v0, v1;
    bit quiet;
    apply_reset();
    do_step((32'd100 << 8) | 32'd200, 8'd150);
    read_state(1, v0, v1);
    checks++;
    if (spike_0 !== 4'b0001 || v0 !== 8'd100) begin
      failures++;
      $display("FAIL abort_setup spike=%b V1=%0d exp spike=0001 V1=100", spike_0, v0);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (done_0 !== 1'b0 || busy_0 !== 1'b0) quiet = 1'b0;
      tick();
    end
    checks++;
    if (!quiet || spike_0 !== 4'b0000) begin
      failures++;
      $display("FAIL abort_quiet no_done_no_busy=%b spike=%b exp 1/0000", quiet, spike_0);
    end
    for (int c = 0; c < 4; c++) begin
      read_state(c, v0, v1);
      checks++;
      if (v0 !== 8'd0) begin
        failures++;
        $display("FAIL abort_state ch%0d got=%0d exp=0", c, v0);
      end
    end
    do_step(32'd100, 8'd150);
    read_state(0, v0, v1);
    checks++;
    if (v0 !== 8'd100 || spike_0 !== 4'b0000) begin
      failures++;
      $display("FAIL abort_restart V0=%0d spike=%b exp V0=100 spike=0000", v0, spike_0);
    end
  endtask

  task automatic test_subtract_mode();
    logic [7:0] v0, v1;
    apply_reset();
    do_step(32'd120 << 16, 8'd150);
    read_state(2, v0, v1);
    checks++;
    if (v1 !== 8'd120 || spike_1 !== 4'b0000) begin
      failures++;
      $display("FAIL sub_step1 V2=%0d spike=%b exp V2=120 spike=0000", v1, spike_1);
    end
    do_step(32'd120 << 16, 8'd150);
    read_state(2, v0, v1);
    checks++;
    if (v1 !== 8'd30 || spike_1 !== 4'b0100) begin
      failures++;
      $display("FAIL sub_step2 V2=%0d spike=%b exp V2=30 spike=0100", v1, spike_1);
    end
    checks++;
    if (v0 !== 8'd0 || spike_0 !== 4'b0100) begin
      failures++;
      $display("FAIL zero_mode_contrast V2=%0d spike=%b exp V2=0 spike=0100", v0, spike_0);
    end
  endtask

  initial begin
    test_reset();
    test_integrate_refrac();
    test_saturation();
    test_thresh_zero();
    test_back_to_back();
    test_abort();
    test_subtract_mode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
